// File: rtl/acc_pkg.sv
// Shared types for the CPU-side accelerator issue path.
package acc_pkg;

    localparam int ACC_NUM_REGS        = 16;
    localparam int ACC_MAX_OUTSTANDING = 4;

    typedef logic [3:0]  reg_addr_t;
    typedef logic [31:0] data_t;
    typedef logic [3:0]  acc_op_t;

    localparam acc_op_t ACC_OP_ADD = 4'd0;
    localparam acc_op_t ACC_OP_SUB = 4'd1;
    localparam acc_op_t ACC_OP_MUL = 4'd2;

    typedef struct packed {
        acc_op_t   op;
        data_t     op1;
        data_t     op2;
        reg_addr_t rd;
    } acc_instr_t;

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } acc_issue_state_e;

endpackage

// File: rtl/acc_scoreboard.sv
// Destination-register scoreboard: pending bits plus an outstanding counter.
module acc_scoreboard
    import acc_pkg::*;
#(
    parameter int NUM_REGS        = ACC_NUM_REGS,
    parameter int MAX_OUTSTANDING = ACC_MAX_OUTSTANDING
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  set_i,
    input  reg_addr_t             set_addr_i,
    input  logic                  clr_i,
    input  reg_addr_t             clr_addr_i,
    input  reg_addr_t [2:0]       q_addr_i,
    output logic      [2:0]       q_pend_o,
    output logic [NUM_REGS-1:0]   pending_o,
    output logic [NUM_REGS-1:0]   pend_eff_o,
    output logic                  empty_o,
    output logic                  full_o,
    output logic                  err_o
);

    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

    logic [NUM_REGS-1:0] pending_q, pending_d;
    logic [NUM_REGS-1:0] set_mask, clr_mask;
    logic [CNT_W-1:0]    cnt_q, cnt_d, eff_cnt;
    logic                err_q, err_d;
    logic                dec;

    // Next scoreboard state; a clear only counts when it hits a pending entry.
    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        dec      = clr_i && pending_q[clr_addr_i];
        if (set_i) set_mask[set_addr_i] = 1'b1;
        if (dec)   clr_mask[clr_addr_i] = 1'b1;
        pending_d = (pending_q & ~clr_mask) | set_mask;
        eff_cnt   = cnt_q - CNT_W'(dec);
        cnt_d     = eff_cnt + CNT_W'(set_i);
        err_d     = err_q | (clr_i && !pending_q[clr_addr_i]);
        for (int k = 0; k < 3; k++) begin
            q_pend_o[k] = pending_d[q_addr_i[k]];
        end
    end

    assign pending_o  = pending_q;
    assign pend_eff_o = pending_q & ~clr_mask;
    assign empty_o    = (cnt_q == '0);
    assign full_o     = (eff_cnt >= CNT_W'(MAX_OUTSTANDING));
    assign err_o      = err_q;

    // Scoreboard registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pending_q <= '0;
            cnt_q     <= '0;
            err_q     <= 1'b0;
        end else begin
            pending_q <= pending_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
        end
    end

endmodule

// File: rtl/acc_issue_unit.sv
// CPU-side accelerator issue unit: issue handshake, hazard-checked reads,
// and regfile write-port arbitration.
// Handshake rule: a transfer happens in a cycle where valid and ready are both
// high; valid never waits on ready and the payload is held stable while valid
// is high and ready is low.
module acc_issue_unit
    import acc_pkg::*;
#(
    parameter int NUM_REGS        = ACC_NUM_REGS,
    parameter int MAX_OUTSTANDING = ACC_MAX_OUTSTANDING
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  acc_instr_t       cpu_instr_i,
    input  logic             cpu_instr_valid_i,
    output logic             cpu_instr_ready_o,
    output acc_instr_t       acc_instr_o,
    output logic             acc_instr_valid_o,
    input  logic             ready_i,
    input  logic             busy_i,
    input  reg_addr_t [2:0]  raddr_i,
    output data_t     [2:0]  rdata_o,
    output logic             rvalid_o,
    input  reg_addr_t        waddr_i,
    input  data_t            wdata_i,
    input  logic             wren_i,
    output data_t            fwd_data_o,
    output logic             fwd_valid_o,
    input  reg_addr_t        cpu_wb_addr_i,
    input  data_t            cpu_wb_data_i,
    input  logic             cpu_wb_valid_i,
    output logic             cpu_wb_ready_o,
    output reg_addr_t [2:0]  rf_raddr_o,
    input  data_t     [2:0]  rf_rdata_i,
    output reg_addr_t        rf_waddr_o,
    output data_t            rf_wdata_o,
    output logic             rf_wren_o,
    output logic             idle_o,
    output logic             err_o,
    output acc_issue_state_e state_o
);

    acc_issue_state_e state_q, state_d;
    acc_instr_t       instr_q, instr_d;
    data_t [2:0]      rdata_q, rdata_d;
    logic             rvalid_q, rvalid_d;
    data_t            fwd_data_q, fwd_data_d;
    logic             fwd_valid_q, fwd_valid_d;

    logic                cpu_hs, wb_hs, state_ok, waw, full, empty;
    logic [2:0]          q_pend;
    logic [NUM_REGS-1:0] pending, pend_eff;

    acc_scoreboard #(
        .NUM_REGS        (NUM_REGS),
        .MAX_OUTSTANDING (MAX_OUTSTANDING)
    ) u_sb (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .set_i      (cpu_hs),
        .set_addr_i (cpu_instr_i.rd),
        .clr_i      (wren_i),
        .clr_addr_i (waddr_i),
        .q_addr_i   (raddr_i),
        .q_pend_o   (q_pend),
        .pending_o  (pending),
        .pend_eff_o (pend_eff),
        .empty_o    (empty),
        .full_o     (full),
        .err_o      (err_o)
    );

    // Issue acceptance: slot free (after writeback), no RAW/WAW on rd.
    always_comb begin
        state_ok = (state_q == IDLE) || ((state_q == REQ) && ready_i);
        waw      = (state_q == REQ) && (instr_q.rd == cpu_instr_i.rd);
        cpu_instr_ready_o = state_ok && !full && !pend_eff[cpu_instr_i.rd] && !waw;
        cpu_hs   = cpu_instr_valid_i && cpu_instr_ready_o;
    end

    // Issue FSM next state; the latched instruction only changes on a CPU handshake.
    always_comb begin
        state_d = state_q;
        instr_d = instr_q;
        case (state_q)
            IDLE: begin
                if (cpu_hs) begin
                    state_d = REQ;
                    instr_d = cpu_instr_i;
                end
            end
            REQ: begin
                if (ready_i) begin
                    if (cpu_hs) instr_d = cpu_instr_i;
                    else        state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Write-port arbitration (accelerator first), read bypass and forwarding.
    always_comb begin
        cpu_wb_ready_o = !wren_i && !pending[cpu_wb_addr_i];
        wb_hs          = cpu_wb_valid_i && cpu_wb_ready_o;
        rf_wren_o      = wren_i || wb_hs;
        rf_waddr_o     = wren_i ? waddr_i : cpu_wb_addr_i;
        rf_wdata_o     = wren_i ? wdata_i : cpu_wb_data_i;
        rf_raddr_o     = raddr_i;
        for (int k = 0; k < 3; k++) begin
            rdata_d[k] = (rf_wren_o && (rf_waddr_o == raddr_i[k])) ? rf_wdata_o
                                                                   : rf_rdata_i[k];
        end
        rvalid_d    = (q_pend == 3'b000);
        fwd_valid_d = wb_hs;
        fwd_data_d  = wb_hs ? cpu_wb_data_i : fwd_data_q;
    end

    // State and output registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            instr_q     <= '0;
            rdata_q     <= '0;
            rvalid_q    <= 1'b0;
            fwd_data_q  <= '0;
            fwd_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            instr_q     <= instr_d;
            rdata_q     <= rdata_d;
            rvalid_q    <= rvalid_d;
            fwd_data_q  <= fwd_data_d;
            fwd_valid_q <= fwd_valid_d;
        end
    end

    assign acc_instr_valid_o = (state_q == REQ);
    assign acc_instr_o       = instr_q;
    assign rdata_o           = rdata_q;
    assign rvalid_o          = rvalid_q;
    assign fwd_data_o        = fwd_data_q;
    assign fwd_valid_o       = fwd_valid_q;
    assign idle_o            = empty && !busy_i;
    assign state_o           = state_q;

endmodule

// File: tb/tb_acc_issue_unit.sv
// Directed bench for acc_issue_unit with a small behavioural regfile.
module tb_acc_issue_unit;
    import acc_pkg::*;

    logic             clk;
    logic             rst_ni;
    acc_instr_t       cpu_instr_i;
    logic             cpu_instr_valid_i;
    logic             cpu_instr_ready_o;
    acc_instr_t       acc_instr_o;
    logic             acc_instr_valid_o;
    logic             ready_i;
    logic             busy_i;
    reg_addr_t [2:0]  raddr_i;
    data_t     [2:0]  rdata_o;
    logic             rvalid_o;
    reg_addr_t        waddr_i;
    data_t            wdata_i;
    logic             wren_i;
    data_t            fwd_data_o;
    logic             fwd_valid_o;
    reg_addr_t        cpu_wb_addr_i;
    data_t            cpu_wb_data_i;
    logic             cpu_wb_valid_i;
    logic             cpu_wb_ready_o;
    reg_addr_t [2:0]  rf_raddr_o;
    data_t     [2:0]  rf_rdata_i;
    reg_addr_t        rf_waddr_o;
    data_t            rf_wdata_o;
    logic             rf_wren_o;
    logic             idle_o;
    logic             err_o;
    acc_issue_state_e state_o;

    int checks = 0;
    int errors = 0;
    acc_instr_t exp_instr;
    data_t regs [16];

    acc_issue_unit dut (
        .clk_i             (clk),
        .rst_ni            (rst_ni),
        .cpu_instr_i       (cpu_instr_i),
        .cpu_instr_valid_i (cpu_instr_valid_i),
        .cpu_instr_ready_o (cpu_instr_ready_o),
        .acc_instr_o       (acc_instr_o),
        .acc_instr_valid_o (acc_instr_valid_o),
        .ready_i           (ready_i),
        .busy_i            (busy_i),
        .raddr_i           (raddr_i),
        .rdata_o           (rdata_o),
        .rvalid_o          (rvalid_o),
        .waddr_i           (waddr_i),
        .wdata_i           (wdata_i),
        .wren_i            (wren_i),
        .fwd_data_o        (fwd_data_o),
        .fwd_valid_o       (fwd_valid_o),
        .cpu_wb_addr_i     (cpu_wb_addr_i),
        .cpu_wb_data_i     (cpu_wb_data_i),
        .cpu_wb_valid_i    (cpu_wb_valid_i),
        .cpu_wb_ready_o    (cpu_wb_ready_o),
        .rf_raddr_o        (rf_raddr_o),
        .rf_rdata_i        (rf_rdata_i),
        .rf_waddr_o        (rf_waddr_o),
        .rf_wdata_o        (rf_wdata_o),
        .rf_wren_o         (rf_wren_o),
        .idle_o            (idle_o),
        .err_o             (err_o),
        .state_o           (state_o)
    );

    // Clock and reset-free regfile model driven by the DUT's rf_* ports.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_ff @(posedge clk) begin
        if (rf_wren_o) regs[rf_waddr_o] <= rf_wdata_o;
    end

    always_comb begin
        for (int k = 0; k < 3; k++) rf_rdata_i[k] = regs[rf_raddr_o[k]];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_ni            = 1'b0;
        cpu_instr_i       = '0;
        cpu_instr_valid_i = 1'b0;
        ready_i           = 1'b0;
        busy_i            = 1'b0;
        raddr_i           = '0;
        waddr_i           = '0;
        wdata_i           = '0;
        wren_i            = 1'b0;
        cpu_wb_addr_i     = '0;
        cpu_wb_data_i     = '0;
        cpu_wb_valid_i    = 1'b0;

        // Reset state
        #2;
        chk("rst_valid", 72'(acc_instr_valid_o), 72'd0);
        chk("rst_rvalid", 72'(rvalid_o), 72'd0);
        chk("rst_err", 72'(err_o), 72'd0);
        chk("rst_fwd_valid", 72'(fwd_valid_o), 72'd0);
        tick();
        tick();
        rst_ni = 1'b1;
        #1;
        chk("rst_idle", 72'(idle_o), 72'd1);
        chk("rst_cpu_ready", 72'(cpu_instr_ready_o), 72'd1);
        tick();

        // ADD to rd=1, accelerator stalls three cycles
        cpu_instr_i       = '{op: ACC_OP_ADD, op1: 32'h3F80_0000, op2: 32'h4000_0000, rd: 4'd1};
        exp_instr         = cpu_instr_i;
        cpu_instr_valid_i = 1'b1;
        ready_i           = 1'b0;
        #1;
        chk("t1_cpu_ready", 72'(cpu_instr_ready_o), 72'd1);
        tick();
        cpu_instr_valid_i = 1'b0;
        cpu_instr_i       = '0;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) ready_i = 1'b1;
            #1;
            chk("t1_req_valid", 72'(acc_instr_valid_o), 72'd1);
            chk("t1_req_instr", 72'(acc_instr_o), 72'(exp_instr));
            if (i < 3) chk("t1_req_stall_ready", 72'(cpu_instr_ready_o), 72'd0);
            tick();
        end
        ready_i = 1'b0;
        #1;
        chk("t1_valid_drop", 72'(acc_instr_valid_o), 72'd0);

        // Read reg 1 while pending, then writeback with same-cycle bypass
        raddr_i[0] = 4'd1;
        tick();
        chk("t2_rvalid_pending", 72'(rvalid_o), 72'd0);
        wren_i  = 1'b1;
        waddr_i = 4'd1;
        wdata_i = 32'h4040_0000;
        #1;
        chk("t2_rf_wren", 72'(rf_wren_o), 72'd1);
        chk("t2_rf_waddr", 72'(rf_waddr_o), 72'd1);
        chk("t2_rf_wdata", 72'(rf_wdata_o), 72'h4040_0000);
        chk("t2_cpu_wb_ready", 72'(cpu_wb_ready_o), 72'd0);
        tick();
        wren_i = 1'b0;
        #1;
        chk("t2_rvalid_after_wb", 72'(rvalid_o), 72'd1);
        chk("t2_rdata0", 72'(rdata_o[0]), 72'h4040_0000);
        chk("t2_idle", 72'(idle_o), 72'd1);
        raddr_i = '0;

        // Fill four slots (rd 2..5), fifth blocked until a writeback frees one
        ready_i           = 1'b1;
        cpu_instr_valid_i = 1'b1;
        cpu_instr_i       = '{op: ACC_OP_MUL, op1: 32'h0000_0011, op2: 32'h0000_0022, rd: 4'd2};
        for (int r = 2; r < 6; r++) begin
            cpu_instr_i.rd = 4'(r);
            #1;
            chk("t3_issue_ready", 72'(cpu_instr_ready_o), 72'd1);
            tick();
        end
        cpu_instr_i.rd = 4'd6;
        exp_instr      = cpu_instr_i;
        #1;
        chk("t3_full_ready", 72'(cpu_instr_ready_o), 72'd0);
        wren_i  = 1'b1;
        waddr_i = 4'd3;
        wdata_i = 32'h0000_0033;
        #1;
        chk("t3_freed_ready", 72'(cpu_instr_ready_o), 72'd1);
        tick();
        wren_i            = 1'b0;
        cpu_instr_valid_i = 1'b0;
        #1;
        chk("t3_fifth_valid", 72'(acc_instr_valid_o), 72'd1);
        chk("t3_fifth_instr", 72'(acc_instr_o), 72'(exp_instr));
        tick();
        ready_i = 1'b0;

        // RAW/WAW stall on rd=2 until reg 2 is written back
        wren_i = 1'b1;
        for (int r = 4; r < 7; r++) begin
            waddr_i = 4'(r);
            tick();
        end
        wren_i            = 1'b0;
        cpu_instr_valid_i = 1'b1;
        cpu_instr_i.rd    = 4'd2;
        #1;
        chk("t4_stall_a", 72'(cpu_instr_ready_o), 72'd0);
        tick();
        chk("t4_stall_b", 72'(cpu_instr_ready_o), 72'd0);
        wren_i  = 1'b1;
        waddr_i = 4'd2;
        #1;
        chk("t4_release", 72'(cpu_instr_ready_o), 72'd1);
        tick();
        wren_i            = 1'b0;
        cpu_instr_valid_i = 1'b0;
        ready_i           = 1'b1;
        tick();
        ready_i = 1'b0;
        wren_i  = 1'b1;
        waddr_i = 4'd2;
        tick();
        wren_i = 1'b0;
        #1;
        chk("t4_idle", 72'(idle_o), 72'd1);
        chk("t4_no_err", 72'(err_o), 72'd0);

        // Accelerator write vs CPU writeback in the same cycle
        cpu_instr_valid_i = 1'b1;
        cpu_instr_i.rd    = 4'd6;
        ready_i           = 1'b1;
        tick();
        cpu_instr_valid_i = 1'b0;
        tick();
        ready_i        = 1'b0;
        wren_i         = 1'b1;
        waddr_i        = 4'd6;
        wdata_i        = 32'hAAAA_0000;
        cpu_wb_valid_i = 1'b1;
        cpu_wb_addr_i  = 4'd7;
        cpu_wb_data_i  = 32'h1234_5678;
        raddr_i[1]     = 4'd7;
        #1;
        chk("t5_wb_blocked", 72'(cpu_wb_ready_o), 72'd0);
        chk("t5_acc_waddr", 72'(rf_waddr_o), 72'd6);
        chk("t5_acc_wdata", 72'(rf_wdata_o), 72'hAAAA_0000);
        tick();
        wren_i = 1'b0;
        #1;
        chk("t5_wb_ready", 72'(cpu_wb_ready_o), 72'd1);
        chk("t5_cpu_wren", 72'(rf_wren_o), 72'd1);
        chk("t5_cpu_waddr", 72'(rf_waddr_o), 72'd7);
        chk("t5_cpu_wdata", 72'(rf_wdata_o), 72'h1234_5678);
        chk("t5_fwd_not_yet", 72'(fwd_valid_o), 72'd0);
        tick();
        cpu_wb_valid_i = 1'b0;
        #1;
        chk("t5_fwd_valid", 72'(fwd_valid_o), 72'd1);
        chk("t5_fwd_data", 72'(fwd_data_o), 72'h1234_5678);
        chk("t5_bypass_rdata1", 72'(rdata_o[1]), 72'h1234_5678);
        tick();
        chk("t5_fwd_drop", 72'(fwd_valid_o), 72'd0);
        chk("t5_rf_rdata1", 72'(rdata_o[1]), 72'h1234_5678);
        raddr_i = '0;

        // Writeback to a register that is not pending
        wren_i  = 1'b1;
        waddr_i = 4'd9;
        wdata_i = 32'h0000_0005;
        #1;
        chk("t6_err_before", 72'(err_o), 72'd0);
        tick();
        wren_i = 1'b0;
        #1;
        chk("t6_err_set", 72'(err_o), 72'd1);
        chk("t6_cnt_kept", 72'(idle_o), 72'd1);
        tick();
        chk("t6_err_sticky", 72'(err_o), 72'd1);

        // Reset in the middle of a request
        cpu_instr_valid_i = 1'b1;
        cpu_instr_i.rd    = 4'd8;
        ready_i           = 1'b0;
        tick();
        cpu_instr_valid_i = 1'b0;
        #1;
        chk("t7_req_valid", 72'(acc_instr_valid_o), 72'd1);
        #2;
        rst_ni = 1'b0;
        #1;
        chk("t7_async_valid", 72'(acc_instr_valid_o), 72'd0);
        chk("t7_async_instr", 72'(acc_instr_o), 72'd0);
        chk("t7_async_err", 72'(err_o), 72'd0);
        tick();
        rst_ni = 1'b1;
        #1;
        chk("t7_idle", 72'(idle_o), 72'd1);
        chk("t7_cpu_ready", 72'(cpu_instr_ready_o), 72'd1);
        tick();
        chk("t7_no_retry_a", 72'(acc_instr_valid_o), 72'd0);
        tick();
        chk("t7_no_retry_b", 72'(acc_instr_valid_o), 72'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/acc_issue_unit.md
# acc_issue_unit

CPU-side counterpart of `acc_top`: accepts accelerator instructions from the CPU EX stage and issues them over the `acc_instr`/valid/ready handshake. It serves the accelerator's three register-read ports with registered, hazard-checked data and arbitrates the single regfile write port between accelerator writebacks and CPU writebacks. A destination-register scoreboard prevents RAW/WAW hazards while up to `MAX_OUTSTANDING` accelerator operations are in flight.

## Interface
- `NUM_REGS`, 16: regfile entries, indexed by `reg_addr_t`.
- `MAX_OUTSTANDING`, 4: maximum issued-but-not-written-back instructions.
- `clk_i` in 1: clock.
- `rst_ni` in 1: reset. One clock; reset is asynchronous and active-low.
- `cpu_instr_i` in `acc_instr_t`: instruction from the CPU.
- `cpu_instr_valid_i` / `cpu_instr_ready_o` in/out 1: CPU-side issue handshake.
- `acc_instr_o` out `acc_instr_t`, `acc_instr_valid_o` out 1: request to the accelerator.
- `ready_i`, `busy_i` in 1: accelerator accept and pipeline-busy.
- `raddr_i` in `reg_addr_t[2:0]`, `rdata_o` out `data_t[2:0]`, `rvalid_o` out 1: accelerator read ports.
- `waddr_i` in `reg_addr_t`, `wdata_i` in `data_t`, `wren_i` in 1: accelerator writeback.
- `fwd_data_o` out `data_t`, `fwd_valid_o` out 1: forwarded CPU writeback.
- `cpu_wb_addr_i`, `cpu_wb_data_i`, `cpu_wb_valid_i` in; `cpu_wb_ready_o` out: CPU writeback.
- `rf_raddr_o[2:0]`, `rf_rdata_i[2:0]`, `rf_waddr_o`, `rf_wdata_o`, `rf_wren_o`: CPU regfile ports.
- `idle_o` out 1: nothing outstanding, `busy_i` low. `err_o` out 1: sticky protocol error.

## Operation
- **FSM**
  - IDLE: `acc_instr_valid_o`=0. On CPU handshake, latch `cpu_instr_i` and go to REQ.
  - REQ: `acc_instr_valid_o`=1 with `acc_instr_o` held stable. On `ready_i`, issue completes: return to IDLE, or stay in REQ if a new CPU handshake occurs in the same cycle.
- **`cpu_instr_ready_o`** (combinational) requires all of:
  - state is IDLE or (REQ and `ready_i`);
  - effective count < `MAX_OUTSTANDING`, where count includes a same-cycle decrement;
  - `pending[cpu_instr_i.rd]`=0 and the latched REQ instruction does not target the same `rd` (WAW stall).
- **Scoreboard**
  - On issue, set `pending[rd]` and increment `cnt`.
  - On `wren_i` to a pending register, clear `pending[waddr_i]` and decrement `cnt`.
  - Increment and decrement in the same cycle leave `cnt` unchanged.
  - `wren_i` to a non-pending register: the write is still performed, `cnt` is unchanged, and `err_o` sets.
- **Write arbitration**
  - Accelerator write has priority: `cpu_wb_ready_o` = !`wren_i` && !`pending[cpu_wb_addr_i]`.
  - `rf_*` carry the accelerator write if `wren_i`, otherwise the CPU writeback on its handshake.
- **Reads**
  - `rf_raddr_o` = `raddr_i` (combinational).
  - `rdata_o[k]` is registered from `rf_rdata_i[k]`, bypassed by a same-cycle regfile write to the same address.
  - `rvalid_o` is registered: 1 iff none of the three addresses is pending after the current cycle's scoreboard update.
- **Forwarding:** `fwd_valid_o`/`fwd_data_o` are registered copies of the CPU writeback handshake and its data.

## Timing
- Reset: outputs go to 0 asynchronously. This covers `acc_instr_valid_o`, `acc_instr_o`, `rvalid_o`, `rdata_o`, `fwd_*`, and `err_o`. `pending` and `cnt` clear and the FSM enters IDLE. `idle_o`=1 and `cpu_instr_ready_o`=1 once `rst_ni` is high.
- Issue latency: a CPU handshake in cycle N gives `acc_instr_valid_o`=1 in N+1. Back-to-back issue sustains 1 instruction/cycle while `ready_i` stays high.
- Read latency: 1 cycle from `raddr_i` to `rdata_o`/`rvalid_o`.
- Accelerator writeback reaches the regfile combinationally in the same cycle. The freed register is issuable in that same cycle.
- Reset asserted mid-REQ: the request is dropped and no retry follows.

## Structure
- `acc_pkg` holds:
  - `acc_instr_t`, `reg_addr_t`, and `data_t` (existing types);
  - new `acc_issue_state_e` {IDLE, REQ};
  - `ACC_MAX_OUTSTANDING`.
- One sub-module, `acc_scoreboard`: pending vector and counter, with set/clear ports and three query ports. It also drives `full_o` and `err_o`.

## Test plan
- ADD, op1=0x3F800000, op2=0x40000000, rd=1, with `ready_i` held low 3 cycles → `acc_instr_o` stable through all 4 cycles of `acc_instr_valid_o`. Then `wren_i`, `waddr_i`=1, `wdata_i`=0x40400000 → `rf_wren_o`=1 with the same data, and `pending[1]` clears.
- Reads of reg 1 while it is pending → `rvalid_o`=0. In the cycle after writeback, `rvalid_o`=1 and `rdata_o[0]`=0x40400000.
- Issue 4 ops to rd=2..5 with no writeback → 5th `cpu_instr_ready_o`=0. Writeback to reg 3 → the 5th is accepted in the same cycle.
- Issue to rd=2 while reg 2 is pending → stalled until the writeback to reg 2.
- Same-cycle `wren_i` (reg 6, 0xAAAA0000) and CPU wb (reg 7, 0x12345678) → accelerator write wins, `cpu_wb_ready_o`=0. The CPU write lands next cycle and `fwd_valid_o`=1 the cycle after.
- `wren_i` to non-pending reg 9 → `err_o`=1 until reset and `cnt` unchanged. Reset asserted mid-REQ → `acc_instr_valid_o` drops immediately.
